// File: rtl/cor_h_engine_pkg.sv
// Shared types and ITU-style fixed-point helpers for the impulse-response
// correlation engine. Build option: COR_H_NORM_EN adds the normalisation helpers.
package cor_h_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} engState_e;

   localparam logic signed [31:0] MAX_POS = 32'sh7FFFFFFF;
   localparam logic signed [31:0] MIN_NEG = 32'sh80000000;

   // Clip a 34-bit intermediate into the 32-bit fractional range.
   function automatic logic signed [31:0] sat32(input logic signed [33:0] x);
      if ((x[33:31] == 3'b000) || (x[33:31] == 3'b111)) begin
         return x[31:0];
      end
      return x[33] ? MIN_NEG : MAX_POS;
   endfunction

   // Fractional multiply: 2*a*b, saturated (only -32768*-32768 clips).
   function automatic logic signed [31:0] L_mult(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
      logic signed [31:0] p;
      p = a * b;
      return sat32({p[31], p, 1'b0});
   endfunction

   // Multiply-accumulate with saturation after the add.
   function automatic logic signed [31:0] L_mac(input logic signed [31:0] acc,
                                                  input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
      logic signed [31:0] t;
      t = L_mult(a, b);
      return sat32({acc[31], acc[31], acc} + {t[31], t[31], t});
   endfunction

`ifdef COR_H_NORM_EN
   // Left shifts needed to bring x into [0x40000000, 0x7FFFFFFF] (or the
   // negative mirror). The highest bit that differs from the sign decides it;
   // 0 yields 0 and -1 yields 31.
   function automatic logic [4:0] norm_l(input logic signed [31:0] x);
      logic [4:0] n;
      n = x[31] ? 5'd31 : 5'd0;
      for (int i = 0; i < 31; i++) begin
         if (x[i] != x[31]) begin
            n = 5'(30 - i);
         end
      end
      return n;
   endfunction

   // Arithmetic left shift with saturation on overflow.
   function automatic logic signed [31:0] L_shl_sat(input logic signed [31:0] x,
                                                      input logic [4:0] sh);
      logic signed [63:0] w;
      w = 64'(x) <<< sh;
      if (w[63:31] == {33{w[63]}}) begin
         return w[31:0];
      end
      return w[63] ? MIN_NEG : MAX_POS;
   endfunction
`endif

endpackage

// File: rtl/cor_h_mem_mux.sv
// Scratch-memory port mux: the test port owns the memory while sel is high,
// otherwise the correlation engine drives it.
module cor_h_mem_mux #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              sel,
   input  logic [ADDR_W-1:0] testReadAddr,
   input  logic [ADDR_W-1:0] testWriteAddr,
   input  logic [DATA_W-1:0] testWriteData,
   input  logic              testWriteEn,
   input  logic [ADDR_W-1:0] engReadAddr,
   input  logic [ADDR_W-1:0] engWriteAddr,
   input  logic [DATA_W-1:0] engWriteData,
   input  logic              engWriteEn,
   output logic [ADDR_W-1:0] memReadAddr,
   output logic [ADDR_W-1:0] memWriteAddr,
   output logic [DATA_W-1:0] memWriteData,
   output logic              memWriteEn
);

   // Pure combinational select of all four memory-port fields.
   always_comb begin
      if (sel) begin
         memReadAddr  = testReadAddr;
         memWriteAddr = testWriteAddr;
         memWriteData = testWriteData;
         memWriteEn   = testWriteEn;
      end else begin
         memReadAddr  = engReadAddr;
         memWriteAddr = engWriteAddr;
         memWriteData = engWriteData;
         memWriteEn   = engWriteEn;
      end
   end

endmodule

// File: rtl/cor_h_engine.sv
// Impulse-response autocorrelation engine: loads h[] from scratch memory,
// computes saturating lagged correlations r[m] and writes them back.
// Build option: COR_H_NORM_EN writes extract_h(r[m] << norm_l(r[0])) instead of raw r[m].
module cor_h_engine
   import cor_h_pkg::*;
#(
   parameter int              ADDR_W   = 12,
   parameter int              DATA_W   = 32,
   parameter int              L_SUBFR  = 40,
   parameter int              NUM_LAGS = 40,
   parameter logic [ADDR_W-1:0] H_BASE = ADDR_W'(12'h000),
   parameter logic [ADDR_W-1:0] R_BASE = ADDR_W'(12'h100)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              test_mux_sel,
   input  logic [ADDR_W-1:0] test_read_addr,
   input  logic [ADDR_W-1:0] test_write_addr,
   input  logic [DATA_W-1:0] test_write_data,
   input  logic              test_write_en,
   output logic [ADDR_W-1:0] mem_read_addr,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en
);

   localparam int IDX_W = $clog2(L_SUBFR + 1);

   engState_e          stateReg, stateNext;
   logic [IDX_W-1:0]   issueIdxReg, issueIdxNext;
   logic               pendReg, pendNext;
   logic [IDX_W-1:0]   pendIdxReg, pendIdxNext;
   logic [IDX_W-1:0]   lagReg, lagNext;
   logic [IDX_W-1:0]   kReg, kNext;
   logic signed [31:0] accReg, accNext;
   logic               captureEn;

   logic signed [15:0] hBuf [L_SUBFR];

   logic [ADDR_W-1:0]  engReadAddr;
   logic [ADDR_W-1:0]  engWriteAddr;
   logic [DATA_W-1:0]  engWriteData;
   logic               engWriteEn;
   logic [DATA_W-1:0]  resultWord;
   logic [IDX_W-1:0]   kPlusLag;
   logic [IDX_W-1:0]   lastK;

   // Only the Q12 low half-word of each h sample is meaningful.
   logic unusedReadBits;
   assign unusedReadBits = ^mem_read_data[DATA_W-1:16];

   assign kPlusLag = kReg + lagReg;
   assign lastK    = IDX_W'(L_SUBFR - 1) - lagReg;
   assign busy     = (stateReg == LOAD) || (stateReg == MAC) || (stateReg == WRITE);
   assign done     = (stateReg == DONE);

`ifdef COR_H_NORM_EN
   logic [4:0]         shiftReg;
   logic [4:0]         curShift;
   logic signed [31:0] shlWord;

   // Lag 0 derives the shift on the fly so the first write needs no extra cycle.
   always_comb begin
      curShift   = (lagReg == '0) ? norm_l(accReg) : shiftReg;
      shlWord    = L_shl_sat(accReg, curShift);
      resultWord = DATA_W'(shlWord >>> 16);
   end

   // Latch the lag-0 shift when its write actually reaches memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         shiftReg <= '0;
      end else if ((stateReg == WRITE) && !test_mux_sel && (lagReg == '0)) begin
         shiftReg <= curShift;
      end
   end
`else
   // Raw saturated correlation goes straight to memory.
   always_comb begin
      resultWord = DATA_W'(accReg);
   end
`endif

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg    <= IDLE;
         issueIdxReg <= '0;
         pendReg     <= 1'b0;
         pendIdxReg  <= '0;
         lagReg      <= '0;
         kReg        <= '0;
         accReg      <= '0;
      end else begin
         stateReg    <= stateNext;
         issueIdxReg <= issueIdxNext;
         pendReg     <= pendNext;
         pendIdxReg  <= pendIdxNext;
         lagReg      <= lagNext;
         kReg        <= kNext;
         accReg      <= accNext;
      end
   end

   // Capture h samples returned by the one-cycle-latency memory.
   always_ff @(posedge clk) begin
      if (captureEn) begin
         hBuf[pendIdxReg] <= mem_read_data[15:0];
      end
   end

   // Next-state logic and engine-side memory requests; sel high freezes progress.
   always_comb begin
      stateNext    = stateReg;
      issueIdxNext = issueIdxReg;
      pendNext     = pendReg;
      pendIdxNext  = pendIdxReg;
      lagNext      = lagReg;
      kNext        = kReg;
      accNext      = accReg;
      captureEn    = 1'b0;
      engReadAddr  = '0;
      engWriteAddr = '0;
      engWriteData = '0;
      engWriteEn   = 1'b0;
      unique case (stateReg)
         IDLE: begin
            if (start) begin
               stateNext    = LOAD;
               issueIdxNext = '0;
               pendNext     = 1'b0;
               pendIdxNext  = '0;
               lagNext      = '0;
               kNext        = '0;
               accNext      = '0;
            end
         end
         LOAD: begin
            if (!test_mux_sel) begin
               captureEn = pendReg;
               if (issueIdxReg < IDX_W'(L_SUBFR)) begin
                  engReadAddr  = H_BASE + ADDR_W'(issueIdxReg);
                  pendNext     = 1'b1;
                  pendIdxNext  = issueIdxReg;
                  issueIdxNext = issueIdxReg + 1'b1;
               end else begin
                  pendNext = 1'b0;
               end
               if (pendReg && (pendIdxReg == IDX_W'(L_SUBFR - 1))) begin
                  stateNext = MAC;
                  kNext     = '0;
                  accNext   = '0;
               end
            end else begin
               // The in-flight read would return test-port data: drop and re-issue it.
               pendNext = 1'b0;
               if (pendReg) begin
                  issueIdxNext = pendIdxReg;
               end
            end
         end
         MAC: begin
            if (!test_mux_sel) begin
               accNext = L_mac(accReg, hBuf[kReg], hBuf[kPlusLag]);
               kNext   = kReg + 1'b1;
               if (kReg == lastK) begin
                  stateNext = WRITE;
               end
            end
         end
         WRITE: begin
            engWriteEn   = 1'b1;
            engWriteAddr = R_BASE + ADDR_W'(lagReg);
            engWriteData = resultWord;
            if (!test_mux_sel) begin
               lagNext   = lagReg + 1'b1;
               kNext     = '0;
               accNext   = '0;
               stateNext = (lagReg == IDX_W'(NUM_LAGS - 1)) ? DONE : MAC;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   cor_h_mem_mux #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) memMux (
      .sel          (test_mux_sel),
      .testReadAddr (test_read_addr),
      .testWriteAddr(test_write_addr),
      .testWriteData(test_write_data),
      .testWriteEn  (test_write_en),
      .engReadAddr  (engReadAddr),
      .engWriteAddr (engWriteAddr),
      .engWriteData (engWriteData),
      .engWriteEn   (engWriteEn),
      .memReadAddr  (mem_read_addr),
      .memWriteAddr (mem_write_addr),
      .memWriteData (mem_write_data),
      .memWriteEn   (mem_write_en)
   );

endmodule

// File: tb/tb_cor_h_engine.sv
// Directed bench for cor_h_engine: a 40/40 instance and an 8/1 instance,
// each with its own synchronous scratch memory sharing one test port bus.
module tb_cor_h_engine;

`ifdef COR_H_NORM_EN
   localparam bit NORM = 1'b1;
`else
   localparam bit NORM = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, startA, startB, selA, selB, tWe;
   logic [11:0] tRa, tWa;
   logic [31:0] tWd;
   logic        busyA, doneA, busyB, doneB;
   logic [11:0] mRaA, mWaA, mRaB, mWaB;
   logic [31:0] mRdA, mWdA, mRdB, mWdB;
   logic        mWeA, mWeB;

   logic [31:0] memA [0:4095];
   logic [31:0] memB [0:4095];

   int errors = 0;
   int checks = 0;

   cor_h_engine dutA (
      .clk(clk), .reset(reset), .start(startA), .busy(busyA), .done(doneA),
      .test_mux_sel(selA), .test_read_addr(tRa), .test_write_addr(tWa),
      .test_write_data(tWd), .test_write_en(tWe),
      .mem_read_addr(mRaA), .mem_read_data(mRdA), .mem_write_addr(mWaA),
      .mem_write_data(mWdA), .mem_write_en(mWeA)
   );

   cor_h_engine #(.L_SUBFR(8), .NUM_LAGS(1)) dutB (
      .clk(clk), .reset(reset), .start(startB), .busy(busyB), .done(doneB),
      .test_mux_sel(selB), .test_read_addr(tRa), .test_write_addr(tWa),
      .test_write_data(tWd), .test_write_en(tWe),
      .mem_read_addr(mRaB), .mem_read_data(mRdB), .mem_write_addr(mWaB),
      .mem_write_data(mWdB), .mem_write_en(mWeB)
   );

   always @(posedge clk) begin
      if (mWeA) memA[mWaA] <= mWdA;
      mRdA <= memA[mRaA];
   end

   always @(posedge clk) begin
      if (mWeB) memB[mWaB] <= mWdB;
      mRdB <= memB[mRaB];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Written word for a raw correlation given the hand-derived shift.
   function automatic logic [31:0] toWord(input logic [31:0] raw, input int sh);
      logic [31:0] w;
      if (NORM) begin
         w = raw << sh;
         return {{16{w[31]}}, w[31:16]};
      end
      return raw;
   endfunction

   // Pattern 0: impulse, 1: all -32768, 2: two taps of 1024.
   function automatic logic [31:0] expRaw(input int pat, input int m);
      case (pat)
         0:       return (m == 0) ? 32'h02000000 : 32'h0;
         1:       return 32'h7FFFFFFF;
         default: return (m == 0) ? 32'h00400000 : (m == 1) ? 32'h00200000 : 32'h0;
      endcase
   endfunction

   function automatic int patShift(input int pat);
      case (pat)
         0:       return 5;
         1:       return 0;
         default: return 8;
      endcase
   endfunction

   function automatic logic [31:0] hWord(input int pat, input int i);
      case (pat)
         0:       return (i == 0) ? 32'h5A5A1000 : 32'hFFFF0000;
         1:       return 32'h00008000;
         default: return (i < 2) ? 32'h00000400 : 32'h0;
      endcase
   endfunction

   task automatic memWr(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      selA = 1'b1; selB = 1'b1;
      tWa = a; tWd = d; tWe = 1'b1;
      @(negedge clk);
      tWe = 1'b0;
   endtask

   task automatic memRd(input logic [11:0] a, output logic [31:0] dA, output logic [31:0] dB);
      @(negedge clk);
      selA = 1'b1; selB = 1'b1;
      tRa = a;
      @(negedge clk);
      dA = mRdA; dB = mRdB;
   endtask

   task automatic releasePort();
      @(negedge clk);
      selA = 1'b0; selB = 1'b0;
   endtask

   task automatic loadH(input int pat);
      for (int i = 0; i < 40; i++) memWr(12'(i), hWord(pat, i));
      for (int m = 0; m < 40; m++) memWr(12'h100 + 12'(m), 32'hDEADBEEF);
      releasePort();
   endtask

   task automatic checkR(input int pat, input string tag);
      logic [31:0] dA, dB;
      for (int m = 0; m < 40; m++) begin
         memRd(12'h100 + 12'(m), dA, dB);
         check($sformatf("%s r[%0d]", tag, m), dA, toWord(expRaw(pat, m), patShift(pat)));
      end
      releasePort();
   endtask

   // Mode 0 plain, 1 stalls, 2 extra start while busy, 3 reset at cycle 300.
   task automatic runA(input int mode, output int cyc, output int nDone,
                       output logic busy0, output logic busyAtDone);
      int  c;
      int  wrStall;
      bit  wrHit;
      bit  stop;
      nDone = 0; cyc = -1; wrStall = 0; wrHit = 1'b0; busy0 = 1'b0; busyAtDone = 1'b1;
      @(negedge clk);
      startA = 1'b1;
      @(posedge clk);
      #1 startA = 1'b0;
      c = 0;
      stop = 1'b0;
      while (!stop && c < 3000) begin
         if (c == 0) busy0 = busyA;
         if (doneA) begin
            nDone++;
            if (cyc < 0) begin
               cyc = c;
               busyAtDone = busyA;
            end
         end
         if (cyc >= 0 && c >= cyc + 6) begin
            stop = 1'b1;
         end else begin
            case (mode)
               1: begin
                  if (c == 10) selA = 1'b1;
                  if (c == 11) begin
                     tWa = 12'h200; tWd = 32'h12345678; tWe = 1'b1;
                     #1;
                     check("pass wr addr", {20'h0, mWaA}, 32'h200);
                     check("pass wr data", mWdA, 32'h12345678);
                     check("pass wr en", {31'h0, mWeA}, 32'h1);
                  end
                  if (c == 12) begin
                     tWe = 1'b0; tRa = 12'h200;
                     #1;
                     check("pass rd addr", {20'h0, mRaA}, 32'h200);
                  end
                  if (c == 13) check("pass rd data", mRdA, 32'h12345678);
                  if (c == 15) selA = 1'b0;
                  if (wrStall > 0) begin
                     wrStall--;
                     if (wrStall == 0) selA = 1'b0;
                  end else if (!wrHit && c > 20 && mWeA) begin
                     selA = 1'b1; wrStall = 3; wrHit = 1'b1;
                  end
               end
               2: begin
                  if (c == 100) startA = 1'b1;
                  if (c == 101) startA = 1'b0;
               end
               3: begin
                  if (c == 300) begin
                     reset = 1'b1;
                     @(posedge clk);
                     #1;
                     check("mid reset busy", {31'h0, busyA}, 32'h0);
                     check("mid reset done", {31'h0, doneA}, 32'h0);
                     check("mid reset we", {31'h0, mWeA}, 32'h0);
                     reset = 1'b0;
                     stop = 1'b1;
                  end
               end
               default: ;
            endcase
            if (!stop) begin
               @(posedge clk);
               #1;
               c++;
            end
         end
      end
   endtask

   initial begin
      int          cyc, nDone, c;
      logic        busy0, busyAtDone;
      logic [31:0] dA, dB;

      reset = 1'b1; startA = 1'b0; startB = 1'b0; selA = 1'b0; selB = 1'b0;
      tWe = 1'b0; tRa = '0; tWa = '0; tWd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset busy", {31'h0, busyA}, 32'h0);
      check("reset done", {31'h0, doneA}, 32'h0);
      check("reset we", {31'h0, mWeA}, 32'h0);
      check("reset waddr", {20'h0, mWaA}, 32'h0);

      // Impulse
      loadH(0);
      runA(0, cyc, nDone, busy0, busyAtDone);
      $display("run impulse: cycles=%0d dones=%0d", cyc, nDone);
      check("impulse latency", cyc, 901);
      check("impulse dones", nDone, 1);
      check("impulse busy start", {31'h0, busy0}, 32'h1);
      check("impulse busy at done", {31'h0, busyAtDone}, 32'h0);
      checkR(0, "impulse");

      // Saturation
      loadH(1);
      runA(0, cyc, nDone, busy0, busyAtDone);
      $display("run saturation: cycles=%0d dones=%0d", cyc, nDone);
      check("sat latency", cyc, 901);
      checkR(1, "sat");

      // Two taps, with a start pulse while busy
      loadH(2);
      runA(2, cyc, nDone, busy0, busyAtDone);
      $display("run two-tap with extra start: cycles=%0d dones=%0d", cyc, nDone);
      check("twotap latency", cyc, 901);
      check("twotap dones", nDone, 1);
      checkR(2, "twotap");

      // Impulse with stalls in LOAD and across the first WRITE
      loadH(0);
      runA(1, cyc, nDone, busy0, busyAtDone);
      $display("run impulse stalled: cycles=%0d dones=%0d", cyc, nDone);
      check("stall latency", cyc, 910);
      check("stall dones", nDone, 1);
      checkR(0, "stall");
      memRd(12'h200, dA, dB);
      releasePort();
      check("test word kept", dA, 32'h12345678);

      // Reset mid-run, then a fresh run
      loadH(2);
      runA(3, cyc, nDone, busy0, busyAtDone);
      $display("run aborted by reset: dones=%0d", nDone);
      check("aborted dones", nDone, 0);
      runA(0, cyc, nDone, busy0, busyAtDone);
      $display("run after reset: cycles=%0d dones=%0d", cyc, nDone);
      check("fresh latency", cyc, 901);
      check("fresh dones", nDone, 1);
      checkR(2, "fresh");

      // Small instance: L=8, one lag, h=1..8
      for (int i = 0; i < 8; i++) memWr(12'(i), 32'(i + 1));
      memWr(12'h100, 32'hDEADBEEF);
      releasePort();
      @(negedge clk);
      startB = 1'b1;
      @(posedge clk);
      #1 startB = 1'b0;
      c = 0;
      while (!doneB && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      $display("run small instance: cycles=%0d", c);
      check("small latency", c, 18);
      check("small busy at done", {31'h0, busyB}, 32'h0);
      memRd(12'h100, dA, dB);
      releasePort();
      check("small r[0]", dB, toWord(32'h00000198, 22));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cor_h_engine.md
Name: cor_h_engine

Overview:
- Parametrised successor to the fixed-size impulse-response correlation pipe in the ACELP codebook path.
- Loads h[0..L_SUBFR-1] (Q12, low 16 bits of each word) from scratch memory into an internal buffer.
- Computes lagged autocorrelations r[m] = sum_{k=0}^{L_SUBFR-1-m} h[k]*h[k+m] with ITU saturating L_mac semantics, for m = 0..NUM_LAGS-1, and writes them back to memory.
- Owns the test/engine memory-port mux; stalls cleanly while the test port holds the memory.

Parameters:
- ADDR_W, 12, scratch memory address width.
- DATA_W, 32, scratch memory data width.
- L_SUBFR, 40, number of h samples (2..64).
- NUM_LAGS, 40, lags computed (1..L_SUBFR).
- H_BASE, 12'h000, address of h[0].
- R_BASE, 12'h100, address of r[0]; r[m] is at R_BASE+m.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse on completion.
- test_mux_sel  in  1  1 = test port owns memory and the engine stalls.
- test_read_addr  in  ADDR_W  test read address.
- test_write_addr  in  ADDR_W  test write address.
- test_write_data  in  DATA_W  test write data.
- test_write_en  in  1  test write enable.
- mem_read_addr  out  ADDR_W  muxed read address to memory.
- mem_read_data  in  DATA_W  memory read data; synchronous, 1-cycle latency.
- mem_write_addr  out  ADDR_W  muxed write address.
- mem_write_data  out  DATA_W  muxed write data.
- mem_write_en  out  1  muxed write enable.

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0; engine write_en=0; engine addresses and data 0; accumulator 0; shift 0.
- Mux: a combinational 4-way mux. test_mux_sel=1 passes the test_* signals through; 0 passes the engine signals.
- States: IDLE -> LOAD -> MAC -> WRITE -> (MAC for the next lag | DONE) -> IDLE.
- IDLE: start=1 -> LOAD, with load and lag counters cleared. start in any other state is ignored.
- LOAD: issues a read of H_BASE+i each cycle. The data is captured into h_buf[i] on the following cycle. Undisturbed, LOAD takes L_SUBFR+1 cycles.
- MAC, per lag m: acc starts at 0; k runs 0..L_SUBFR-1-m, one term per cycle.
  - Term: acc = sat32(acc + L_mult(h[k], h[k+m])).
  - L_mult(a,b) = sat32(2*a*b), so (-32768)*(-32768) gives 0x7FFFFFFF.
  - Saturation is applied at every step.
- WRITE: one cycle with engine write_en=1, address R_BASE+m, data r[m]. Then m++; if m==NUM_LAGS go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Latency, undisturbed: done is high exactly L_SUBFR+1+sum_{m<NUM_LAGS}(L_SUBFR-m+1) cycles after the start-sample edge. For 40/40 this is 901 cycles.
- Stall (test_mux_sel=1 while busy):
  - All engine state is held; the engine write is suppressed and replayed once sel returns to 0.
  - A LOAD read is captured only if sel=0 in both the issue cycle and the capture cycle; otherwise it is re-issued.
  - Results are identical to an unstalled run.
- reset mid-operation returns to IDLE with the reset values above; partial results already written stay in memory.
- sel=1 while IDLE: pure passthrough with no engine effect.

Optional Feature:
- Macro: COR_H_NORM_EN.
- Defined:
  - At the end of lag 0, shift = norm_l(r[0]) (norm_l(0)=0) is latched.
  - Every written word is the sign extension of extract_h(L_shl_sat(r[m], shift)) to DATA_W.
  - Adds no extra cycles; the shift is computed combinationally in WRITE for m=0.
- Undefined: the raw saturated 32-bit r[m] is written, and no norm logic is synthesised.

Decomposition:
- Package cor_h_pkg:
  - state enum (IDLE, LOAD, MAC, WRITE, DONE);
  - MAX_POS=32'h7FFFFFFF and MIN_NEG=32'h80000000;
  - sat32, L_mult and L_mac helper functions;
  - norm_l function under the macro.
- One natural sub-module: cor_h_mem_mux, the 4-way test/engine port mux.

Test Plan:
- Impulse, no norm: h[0]=4096, rest 0, L=40, lags=40.
  - r[0]=0x02000000, r[1..39]=0.
  - done exactly 901 cycles after start; busy deasserts together with done.
- Saturation: all h=-32768 -> r[0..39] all 0x7FFFFFFF.
- Two taps, h[0]=h[1]=1024:
  - No norm: r[0]=0x00400000, r[1]=0x00200000, others 0.
  - COR_H_NORM_EN: shift=8; words 0x00004000, 0x00002000, 0.
- Stall: test_mux_sel=1 for 5 cycles mid-LOAD and 3 cycles across a WRITE.
  - r[] identical to the impulse run.
  - While sel=1, test writes and reads at 12'h200 pass through unchanged.
- Control: start pulsed while busy is ignored, with one done per run. reset at cycle 300 -> busy=0, done=0, mem_write_en=0 next cycle; a fresh start then completes correctly.
- Override L_SUBFR=8, NUM_LAGS=1, h=1..8 -> r[0]=2*204=408=0x198, done after 9+9=18 cycles.
